// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decoder.
//
// Holds the fetch PC, issues in-order word requests to instruction memory,
// buffers returned words with their PC in a small prefetch FIFO and hands them
// to decode. A redirect flushes the FIFO and drops every response still in
// flight, then restarts fetch from the new PC on the following cycle.
//
// Handshakes: every channel transfers on a rising edge where its valid and
// ready are both high; a valid, once raised, holds its payload stable until
// accepted (the request channel may only be withdrawn by a redirect).
//
// Parameters:
//   RESET_PC  first fetch address after reset
//   DEPTH     prefetch FIFO entries and max outstanding requests (power of 2, >=2)
//
// Optional feature macro: FETCH_BYPASS_EN
//   defined   - a response arriving while the FIFO is empty and nothing is being
//               dropped is presented to decode in the same cycle
//   undefined - every response goes through the FIFO (1 cycle latency)
//
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   imem_req_valid/ready/addr           request channel to instruction memory
//   imem_resp_valid/data                in-order responses, always accepted
//   redirect, redirect_pc               flush and restart fetch (1-cycle pulse)
//   inst_valid/ready, instruction, inst_pc   instruction channel to decode
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic          started_q;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0] fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
  logic [PW-1:0] infl_wr_q, infl_wr_d, infl_rd_q, infl_rd_d;
  logic [31:0]   fifo_pc_q   [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];
  logic [31:0]   infl_pc_q   [DEPTH];

  logic [CW:0] occupancy;
  logic        req_fire;
  logic        resp_keep;
  logic        fifo_empty;
  logic        bypass;
  logic        fifo_push;
  logic        fifo_pop;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^redirect_pc[1:0];

  // Buffered plus in-flight never exceeds DEPTH, so every kept response has a slot.
  assign occupancy      = {1'b0, fifo_cnt_q} + {1'b0, outst_q};
  assign imem_req_valid = started_q && !redirect && (occupancy < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses owed to pre-redirect requests are counted by drop_q and discarded.
  assign resp_keep  = imem_resp_valid && !redirect && (drop_q == '0);
  assign fifo_empty = (fifo_cnt_q == '0);

`ifdef FETCH_BYPASS_EN
  assign bypass = fifo_empty && resp_keep;
`else
  assign bypass = 1'b0;
`endif

  assign inst_valid  = !fifo_empty || bypass;
  assign instruction = bypass ? imem_resp_data       : fifo_data_q[fifo_rd_q];
  assign inst_pc     = bypass ? infl_pc_q[infl_rd_q] : fifo_pc_q[fifo_rd_q];

  // A bypassed word taken by decode this cycle never needs a FIFO slot.
  assign fifo_push = resp_keep && !(bypass && inst_ready);
  assign fifo_pop  = !fifo_empty && inst_ready && !redirect;

  always_comb begin
    pc_d       = pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    fifo_cnt_d = fifo_cnt_q;
    fifo_wr_d  = fifo_wr_q;
    fifo_rd_d  = fifo_rd_q;
    infl_wr_d  = infl_wr_q;
    infl_rd_d  = infl_rd_q;
    if (redirect) begin
      // No request can fire this cycle; whatever has not returned yet is dropped.
      pc_d       = {redirect_pc[31:2], 2'b00};
      outst_d    = outst_q - CW'(imem_resp_valid);
      drop_d     = outst_q - CW'(imem_resp_valid);
      fifo_cnt_d = '0;
      fifo_wr_d  = '0;
      fifo_rd_d  = '0;
      infl_wr_d  = '0;
      infl_rd_d  = '0;
    end else begin
      if (req_fire) begin
        pc_d      = pc_q + 32'd4;
        infl_wr_d = infl_wr_q + PW'(1);
      end
      outst_d = outst_q + CW'(req_fire) - CW'(imem_resp_valid);
      if (imem_resp_valid && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      // Dropped responses have no entry in the in-flight PC queue.
      if (resp_keep) begin
        infl_rd_d = infl_rd_q + PW'(1);
      end
      if (fifo_push) begin
        fifo_wr_d = fifo_wr_q + PW'(1);
      end
      if (fifo_pop) begin
        fifo_rd_d = fifo_rd_q + PW'(1);
      end
      fifo_cnt_d = fifo_cnt_q + CW'(fifo_push) - CW'(fifo_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      started_q  <= 1'b0;
      outst_q    <= '0;
      drop_q     <= '0;
      fifo_cnt_q <= '0;
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
      infl_wr_q  <= '0;
      infl_rd_q  <= '0;
    end else begin
      pc_q       <= pc_d;
      started_q  <= 1'b1;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      fifo_cnt_q <= fifo_cnt_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_rd_q  <= fifo_rd_d;
      infl_wr_q  <= infl_wr_d;
      infl_rd_q  <= infl_rd_d;
    end
  end

  // Storage is cleared on reset so instruction/inst_pc read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc_q[i]   <= '0;
        fifo_data_q[i] <= '0;
        infl_pc_q[i]   <= '0;
      end
    end else if (!redirect) begin
      if (req_fire) begin
        infl_pc_q[infl_wr_q] <= pc_q;
      end
      if (fifo_push) begin
        fifo_pc_q[fifo_wr_q]   <= infl_pc_q[infl_rd_q];
        fifo_data_q[fifo_wr_q] <= imem_resp_data;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit (RESET_PC=0x100, DEPTH=2).
// The memory model returns addr ^ 0x00500093 for each word, in order, after a
// programmable latency. Expected {pc, instruction} pairs are queued by the
// stimulus and popped by a monitor on every decode handshake.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [31:0] inst_pc;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;
  int hs_count = 0;

  logic [63:0] exp_q[$];
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];

  fetch_unit #(.RESET_PC(32'h0000_0100), .DEPTH(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .instruction     (instruction),
    .inst_pc         (inst_pc)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h0050_0093;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- memory model ----------------
  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mem_addr_q.delete();
        mem_due_q.delete();
      end else if (imem_req_valid && imem_req_ready) begin
        mem_addr_q.push_back(imem_req_addr);
        mem_due_q.push_back(cyc + lat);
      end
      @(posedge clk);
      cyc++;
      #1;
      if (rst_n && mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(mem_addr_q.pop_front());
        void'(mem_due_q.pop_front());
      end else begin
        imem_resp_valid = 1'b0;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && !redirect && inst_valid && inst_ready) begin
        hs_count++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_inst: got pc=%h instr=%h, required no instruction", inst_pc, instruction);
        end else begin
          e = exp_q.pop_front();
          if ({inst_pc, instruction} !== e) begin
            errors++;
            $display("FAIL inst_check: got pc=%h instr=%h, required pc=%h instr=%h",
                     inst_pc, instruction, e[63:32], e[31:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_seq(input logic [31:0] start, input int n);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = start + 32'(4 * i);
      exp_q.push_back({a, mem_word(a)});
    end
  endtask

  task automatic consume(input int n);
    int target;
    target = hs_count + n;
    tick();
    inst_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (hs_count >= target) break;
    end
    inst_ready = 1'b0;
    if (hs_count < target) begin
      checks++;
      errors++;
      $display("FAIL consume_timeout: got %0d handshakes, required %0d", hs_count, target);
      exp_q.delete();
    end
  endtask

  task automatic redirect_pulse(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    tick();
    redirect    = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    bit found;
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    redirect       = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check32("rst_req_valid",   32'(imem_req_valid), 32'h0);
    check32("rst_req_addr",    imem_req_addr,       32'h0000_0100);
    check32("rst_inst_valid",  32'(inst_valid),     32'h0);
    check32("rst_instruction", instruction,         32'h0);
    check32("rst_inst_pc",     inst_pc,             32'h0);

    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check32("prestart_req_valid", 32'(imem_req_valid), 32'h0);
    @(negedge clk);
    check32("first_req_valid", 32'(imem_req_valid), 32'h1);
    check32("first_req_addr",  imem_req_addr,       32'h0000_0100);

    // Sequential fetch from RESET_PC.
    push_seq(32'h0000_0100, 8);
    consume(8);

    // Decode stalled for 5 cycles: fetch must stop once buffer + in-flight is full.
    repeat (5) tick();
    @(negedge clk);
    check32("stall_req_valid",  32'(imem_req_valid), 32'h0);
    check32("stall_inst_valid", 32'(inst_valid),     32'h1);
    push_seq(32'h0000_0120, 6);
    consume(6);

    // Redirect with two responses outstanding.
    tick();
    lat = 3;
    redirect_pulse(32'h0000_0300);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_addr_q.size() == 2 && !imem_resp_valid) begin
        found = 1'b1;
        break;
      end
    end
    check32("two_outstanding_reached", 32'(found), 32'h1);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0203;
    lat         = 1;
    @(negedge clk);
    check32("redir_cycle_req_valid", 32'(imem_req_valid), 32'h0);
    tick();
    redirect = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req_valid) begin
        found = 1'b1;
        break;
      end
    end
    check32("redir_req_seen",   32'(found),    32'h1);
    check32("redir_first_addr", imem_req_addr, 32'h0000_0200);
    push_seq(32'h0000_0200, 4);
    consume(4);

    // Redirect coinciding with a response and a decode handshake.
    tick();
    redirect_pulse(32'h0000_0380);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_resp_valid && inst_valid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check32("resp_and_valid_reached", 32'(found), 32'h1);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0400;
    inst_ready  = 1'b1;
    tick();
    redirect   = 1'b0;
    inst_ready = 1'b0;
    @(negedge clk);
    check32("post_redir_inst_valid", 32'(inst_valid), 32'h0);
    push_seq(32'h0000_0400, 2);
    consume(2);

    // PC wrap-around at the top of the address space.
    tick();
    redirect_pulse(32'hFFFF_FFF8);
    push_seq(32'hFFFF_FFF8, 4);
    consume(4);

    // Response-to-decode latency from an empty FIFO, address 0.
    tick();
    imem_req_ready = 1'b0;
    repeat (3) tick();
    redirect       = 1'b1;
    redirect_pc    = 32'h0000_0000;
    imem_req_ready = 1'b1;
    tick();
    redirect = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_resp_valid) begin
        found = 1'b1;
        break;
      end
    end
    check32("lat_resp_seen", 32'(found), 32'h1);
`ifdef FETCH_BYPASS_EN
    check32("lat_same_cycle_valid", 32'(inst_valid), 32'h1);
    check32("lat_same_cycle_instr", instruction,     32'h0050_0093);
    check32("lat_same_cycle_pc",    inst_pc,         32'h0);
`else
    check32("lat_same_cycle_valid", 32'(inst_valid), 32'h0);
`endif
    @(negedge clk);
    check32("lat_next_valid", 32'(inst_valid), 32'h1);
    check32("lat_next_instr", instruction,     32'h0050_0093);
    check32("lat_next_pc",    inst_pc,         32'h0);
    push_seq(32'h0000_0000, 3);
    consume(3);

    // Request held stable while memory is not ready.
    tick();
    redirect       = 1'b1;
    redirect_pc    = 32'h0000_0500;
    imem_req_ready = 1'b0;
    tick();
    redirect = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check32("hold_req_valid", 32'(imem_req_valid), 32'h1);
      check32("hold_req_addr",  imem_req_addr,       32'h0000_0500);
    end
    tick();
    imem_req_ready = 1'b1;
    push_seq(32'h0000_0500, 3);
    consume(3);

    // Reset asserted mid-operation.
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check32("midrst_inst_valid", 32'(inst_valid),     32'h0);
    check32("midrst_req_valid",  32'(imem_req_valid), 32'h0);
    check32("midrst_req_addr",   imem_req_addr,       32'h0000_0100);
    tick();
    rst_n = 1'b1;
    push_seq(32'h0000_0100, 3);
    consume(3);

    repeat (3) tick();
    check32("exp_q_empty", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
